// File: rtl/multicycle_state_ctrl_if.sv
// multicycle_state_ctrl_if: instruction-in / stage-and-flag-out bundle of the multi-cycle controller
interface multicycle_state_ctrl_if #(
    parameter int INS_W = 32,
    parameter int CNT_W = 32
);
    logic [INS_W-1:0] InsIn;
    logic [INS_W-1:0] IROut;
    logic [2:0]       State;
    logic [5:0]       Opcode;
    logic             IRWre;
    logic             InsDone;
    logic             Halted;
    logic [CNT_W-1:0] CycleCnt;
    logic [CNT_W-1:0] InstrCnt;

    modport master (
        input  InsIn,
        output IROut, State, Opcode, IRWre, InsDone, Halted, CycleCnt, InstrCnt
    );

    modport slave (
        output InsIn,
        input  IROut, State, Opcode, IRWre, InsDone, Halted, CycleCnt, InstrCnt
    );
endinterface

// File: rtl/multicycle_state_ctrl.sv
// multicycle_state_ctrl: IR + stage register of the multi-cycle CPU controller, with sticky halt.
// PERF_CNT_EN adds free-running cycle and retired-instruction counters.
module multicycle_state_ctrl #(
    parameter int INS_W = 32,
    parameter int CNT_W = 32
) (
    input logic                     CLK,
    input logic                     Reset,
    multicycle_state_ctrl_if.master bus
);
    localparam logic [2:0] IF = 3'b000, ID = 3'b001, EXE3 = 3'b101, EXE4 = 3'b110;
    localparam logic [2:0] EXE5 = 3'b010, MEM = 3'b011, WB4 = 3'b111, WB5 = 3'b100;
    localparam logic [5:0] ADD = 6'b000000, SUB = 6'b000001, ADDI = 6'b000010, OR = 6'b010000;
    localparam logic [5:0] AND = 6'b010001, ORI = 6'b010010, SLL = 6'b011000, MOVE = 6'b100000;
    localparam logic [5:0] SLT = 6'b100111, SW = 6'b110000, LW = 6'b110001, BEQ = 6'b110100;
    localparam logic [5:0] HALT = 6'b111111;

    logic [2:0]       state_q, state_d;
    logic [INS_W-1:0] ir_q, ir_d;
    logic             halted_q, halted_d;
    logic [5:0]       op, ins_op;
    logic             irwre, ins_done, is_alu, is_mem, is_beq;

    assign op     = ir_q[INS_W-1 -: 6];
    assign ins_op = bus.InsIn[INS_W-1 -: 6];
    assign is_alu = op inside {ADD, SUB, ADDI, OR, AND, ORI, SLL, MOVE, SLT};
    assign is_mem = op inside {SW, LW};
    assign is_beq = op == BEQ;
    // Once halted nothing is fetched again, whatever InsIn shows.
    assign irwre  = state_q == IF && ins_op != HALT && !halted_q;

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q  <= IF;
            ir_q     <= '0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ir_q     <= ir_d;
            halted_q <= halted_d;
        end
    end

    always_comb begin
        ir_d     = irwre ? bus.InsIn : ir_q;
        halted_d = halted_q | (state_q == IF && ins_op == HALT);
        case (state_q)
            IF:      state_d = irwre ? ID : IF;
            ID:      state_d = is_beq ? EXE3 : is_mem ? EXE5 : is_alu ? EXE4 : IF;
            EXE4:    state_d = WB4;
            EXE5:    state_d = MEM;
            MEM:     state_d = op == LW ? WB5 : IF;
            default: state_d = IF;
        endcase
    end

    always_comb begin
        ins_done = (state_q == ID && !(is_beq || is_mem || is_alu)) || state_q == EXE3 ||
                   state_q == WB4 || (state_q == MEM && op == SW) || state_q == WB5;
    end

    assign bus.State   = state_q;
    assign bus.IROut   = ir_q;
    assign bus.Opcode  = op;
    assign bus.IRWre   = irwre;
    assign bus.InsDone = ins_done;
    assign bus.Halted  = halted_q;

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] cyc_q, cyc_d, ins_q, ins_d;

    always_comb begin
        cyc_d = halted_q ? cyc_q : cyc_q + CNT_W'(1);
        ins_d = (!halted_q && ins_done) ? ins_q + CNT_W'(1) : ins_q;
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            cyc_q <= '0;
            ins_q <= '0;
        end else begin
            cyc_q <= cyc_d;
            ins_q <= ins_d;
        end
    end

    assign bus.CycleCnt = cyc_q;
    assign bus.InstrCnt = ins_q;
`else
    assign bus.CycleCnt = '0;
    assign bus.InstrCnt = '0;
`endif
endmodule

// File: tb/tb_multicycle_state_ctrl.sv
// tb_multicycle_state_ctrl: directed scoreboard bench for the multi-cycle stage controller
module tb_multicycle_state_ctrl;
    localparam int W = 32;
    localparam int C = 32;

    typedef struct {
        logic [2:0]  st;
        logic        done;
        logic [31:0] ir;
        logic        irwre;
        logic        halted;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multicycle_state_ctrl_if #(.INS_W(W), .CNT_W(C)) bus ();
    multicycle_state_ctrl #(.INS_W(W), .CNT_W(C)) dut (.CLK(clk), .Reset(rst), .bus(bus.master));

    exp_t        q[$];
    int          total = 0;
    int          bad = 0;
    logic [31:0] m_cyc = 0, m_ins = 0, prev_ir = 0;
    logic        m_halt = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [2:0] st, input logic done, input logic [31:0] ir,
                        input logic irwre, input logic halted);
        exp_t e;
        e.st = st; e.done = done; e.ir = ir; e.irwre = irwre; e.halted = halted;
        q.push_back(e);
    endtask

    task automatic check_pop();
        exp_t e;
        if (q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            e = q.pop_front();
            chk("State", 32'(bus.State), 32'(e.st));
            chk("InsDone", 32'(bus.InsDone), 32'(e.done));
            chk("IROut", bus.IROut, e.ir);
            chk("Opcode", 32'(bus.Opcode), 32'(e.ir[31:26]));
            chk("IRWre", 32'(bus.IRWre), 32'(e.irwre));
            chk("Halted", 32'(bus.Halted), 32'(e.halted));
`ifdef PERF_CNT_EN
            chk("CycleCnt", bus.CycleCnt, m_cyc);
            chk("InstrCnt", bus.InstrCnt, m_ins);
`else
            chk("CycleCnt", bus.CycleCnt, 32'd0);
            chk("InstrCnt", bus.InstrCnt, 32'd0);
`endif
        end
    endtask

    task automatic step(input logic r, input logic done, input logic halt_now);
        rst = r;
        @(posedge clk);
        if (r) begin
            m_cyc = 0; m_ins = 0; m_halt = 1'b0;
        end else if (!m_halt) begin
            m_cyc++;
            if (done) m_ins++;
            if (halt_now) m_halt = 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic seq_of(input logic [31:0] ins, output logic [2:0] s[5], output int n);
        logic [5:0] op;
        op = ins[31:26];
        s[0] = 3'b000; s[1] = 3'b001; s[2] = 3'b000; s[3] = 3'b000; s[4] = 3'b000;
        n = 2;
        if (op == 6'b110100) begin
            s[2] = 3'b101; n = 3;
        end else if (op == 6'b110000) begin
            s[2] = 3'b010; s[3] = 3'b011; n = 4;
        end else if (op == 6'b110001) begin
            s[2] = 3'b010; s[3] = 3'b011; s[4] = 3'b100; n = 5;
        end else if (op inside {6'b000000, 6'b000001, 6'b000010, 6'b010000, 6'b010001,
                                6'b010010, 6'b011000, 6'b100000, 6'b100111}) begin
            s[2] = 3'b110; s[3] = 3'b111; n = 4;
        end
    endtask

    // Runs an instruction to completion; stop_at < n asserts Reset in that cycle instead.
    task automatic do_instr(input logic [31:0] ins, input int stop_at);
        logic [2:0] s[5];
        int n, last;
        seq_of(ins, s, n);
        last = (stop_at < n) ? stop_at + 1 : n;
        for (int i = 0; i < last; i++)
            push(s[i], (i == n - 1), (i == 0) ? prev_ir : ins, (i == 0), 1'b0);
        prev_ir = ins;
        for (int i = 0; i < last; i++) begin
            bus.InsIn = (i == 0) ? ins : {6'b010000, 26'($urandom)};
            #1;
            check_pop();
            if (i == stop_at) begin
                step(1'b1, 1'b0, 1'b0);
                prev_ir = 0;
            end else begin
                step(1'b0, (i == n - 1), 1'b0);
            end
        end
    endtask

    task automatic fetch_check_after_reset(input logic [31:0] ins);
        bus.InsIn = ins;
        #1;
        push(3'b000, 1'b0, 32'd0, 1'b1, 1'b0);
        check_pop();
    endtask

    initial begin
        logic [31:0] frz_cyc, frz_ins;
        bus.InsIn = 32'h0;
        @(negedge clk);
        step(1'b1, 1'b0, 1'b0);
        fetch_check_after_reset(32'h0022_1820);

        do_instr(32'h0022_1820, 99);
        do_instr(32'hC4A3_0004, 99);
        do_instr(32'hE000_0040, 99);

        bus.InsIn = 32'hFC00_0000;
        #1;
        push(3'b000, 1'b0, prev_ir, 1'b0, 1'b0);
        check_pop();
`ifdef PERF_CNT_EN
        chk("CycleCnt_at_halt", bus.CycleCnt, 32'd11);
        chk("InstrCnt_at_halt", bus.InstrCnt, 32'd3);
`endif
        step(1'b0, 1'b0, 1'b1);
        frz_cyc = bus.CycleCnt;
        frz_ins = bus.InstrCnt;
        for (int i = 0; i < 11; i++) begin
            bus.InsIn = (i < 6) ? 32'hFC00_0000 : 32'h0022_1820;
            #1;
            push(3'b000, 1'b0, prev_ir, 1'b0, 1'b1);
            check_pop();
            step(1'b0, 1'b0, 1'b0);
        end
        chk("CycleCnt_frozen", bus.CycleCnt, frz_cyc);
        chk("InstrCnt_frozen", bus.InstrCnt, frz_ins);

        step(1'b1, 1'b0, 1'b0);
        prev_ir = 0;
        fetch_check_after_reset(32'h0022_1820);

        do_instr(32'hC4A3_0004, 99);
        do_instr(32'hC0A3_0008, 99);
        do_instr(32'hD022_0003, 99);
        do_instr(32'hE800_0010, 99);
        do_instr(32'h0C00_0000, 99);
        do_instr(32'h6000_0080, 99);
        do_instr(32'hE400_0000, 99);

        do_instr(32'hC4A3_0010, 3);
        fetch_check_after_reset(32'h0420_0001);
        do_instr(32'h0420_0001, 99);
        do_instr(32'h4822_FFFF, 99);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/multicycle_state_ctrl.md
Name: multicycle_state_ctrl

Overview:
- Sequential half of the multi-cycle CPU controller.
- Owns the instruction register and the 3-bit stage register.
- Computes the next stage from the latched opcode and drives State/Opcode into the combinational control-signal decoder, which generates PCWre, RegWre, ALUOp and the rest.
- Also flags instruction completion and halt.

Parameters:
- INS_W, 32, instruction word width; opcode is bits [INS_W-1:INS_W-6].
- CNT_W, 32, width of the optional performance counters.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- InsIn  input  INS_W  instruction word from instruction memory (combinational read at current PC).
- State  output  3  current stage, registered.
- IROut  output  INS_W  instruction register contents, registered.
- Opcode  output  6  IROut[INS_W-1:INS_W-6].
- IRWre  output  1  high when State==IF and InsIn opcode != halt; IR loads on this.
- InsDone  output  1  combinational; high in the last stage of the current instruction.
- Halted  output  1  registered sticky halt flag.
- CycleCnt  output  CNT_W  cycles since reset (optional feature).
- InstrCnt  output  CNT_W  retired instructions (optional feature).

Behaviour:
- Interface: one clock, CLK. Reset is synchronous, active-high, named Reset.
- Stage encoding:
  - IF=000, ID=001, EXE_3stages=101, EXE_4stages=110, EXE_5stages=010
  - MEM=011, WB_4stages=111, WB_5stages=100
- Opcodes:
  - add=000000, sub=000001, addi=000010, Or=010000, And=010001, ori=010010
  - sll=011000, move=100000, slt=100111, sw=110000, lw=110001, beq=110100
  - j=111000, jr=111001, jal=111010, halt=111111
- Reset (Reset=1 at a clock edge): State=IF, IROut=0, Halted=0, counters=0. Reset overrides every other event, including mid-instruction and while halted.
- IF:
  - If InsIn opcode==halt: stay in IF, IR not loaded, Halted<=1.
  - Otherwise: IR<=InsIn, State<=ID.
- ID, by IROut opcode:
  - j, jal, jr -> IF; InsDone=1 in ID.
  - beq -> EXE_3stages.
  - lw, sw -> EXE_5stages.
  - add, sub, addi, ori, And, Or, move, sll, slt -> EXE_4stages.
  - Any other opcode -> IF; treated as a NOP, InsDone=1 in ID.
- EXE_3stages -> IF; InsDone=1.
- EXE_4stages -> WB_4stages -> IF; InsDone=1 in WB_4stages.
- EXE_5stages -> MEM.
  - MEM with sw -> IF; InsDone=1 in MEM.
  - MEM with lw -> WB_5stages -> IF; InsDone=1 in WB_5stages.
  - MEM with any other opcode (unreachable) -> IF.
- Unused encodings (none exist in 3 bits besides the eight above): default branch -> IF.
- Latency per instruction, IF through completion:
  - j/jal/jr: 2 cycles. beq: 3 cycles. R/I ALU ops: 4 cycles. sw: 4 cycles. lw: 5 cycles.
- IR holds its value in every state except IF; it changes only on an IF edge with IRWre=1.
- Halted is sticky until Reset. While halted, State stays IF and IROut is frozen.
- Opcode is always derived from IROut, never from InsIn. The exception is the IRWre/halt check in IF, which uses InsIn.

Optional Feature:
- Macro PERF_CNT_EN.
- Defined:
  - CycleCnt increments every cycle with Reset=0 and Halted=0.
  - InstrCnt increments on every edge where InsDone=1.
  - Both wrap modulo 2^CNT_W. Both freeze while Halted.
- Undefined: CycleCnt and InstrCnt are driven constant 0 and no counter registers exist.

Test Plan:
- Reset, then InsIn=add (0x00000000-class, opcode 000000) -> State sequence 000,001,110,111,000. InsDone high only in cycle 4. IROut latched after cycle 1.
- lw (opcode 110001) -> State 000,001,010,011,100,000; InsDone in the WB_5stages cycle. Then sw (110000) -> 000,001,010,011,000.
- beq (110100) -> 000,001,101,000. Then jal (111010) -> 000,001,000 with InsDone in ID. IR unchanged between IF edges.
- InsIn opcode=111111 in IF -> IRWre=0, State stays 000 for 10+ cycles, Halted=1, IROut keeps the previous instruction. Then assert Reset -> Halted=0, IROut=0, State=000.
- Reset asserted while State=MEM (lw) -> next edge State=000, IROut=0. No WB_5stages cycle, no InsDone.
- With PERF_CNT_EN defined: run add, lw, j, then halt -> InstrCnt=3, CycleCnt=11 at halt detection, both then frozen. With the macro undefined, both read 0 throughout.
